arf_err_stat: RTL and testbench
===============================

ARF_ERR_STAT -- requirements
Module: arf_err_stat

Interface
REQ-001 SHALL have parameter WIDTH, default 32, sample width of each filter output.
REQ-002 SHALL have parameter NCH, default 2, number of compared output channels.
REQ-003 SHALL have parameter NSAMP, default 100, number of samples per run, range 1..2^16-1.
REQ-004 SHALL have parameter ACC_W, default 64, accumulator width, at least WIDTH+16.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-007 SHALL have port start, input, 1, single-cycle request that begins a run.
REQ-008 SHALL have port in_valid, input, 1, sample pair present.
REQ-009 SHALL have port in_ready, output, 1, block accepts a sample pair.
REQ-010 SHALL have port var_out, input, NCH*WIDTH, approximate (variance) filter outputs; channel k at bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port acc_out, input, NCH*WIDTH, accurate filter outputs; same packing as var_out.
REQ-012 SHALL have port ch_sel, input, max(1,$clog2(NCH)), statistics readback channel select.
REQ-013 SHALL have port sum_err, output, ACC_W, signed sum of errors for channel ch_sel.
REQ-014 SHALL have port max_abs, output, WIDTH, unsigned maximum absolute error for channel ch_sel.
REQ-015 SHALL have port count, output, 16, accepted sample count in the current run.
REQ-016 SHALL have ports busy and done, output, 1 each, run in progress and run complete.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE; DONE -> RUN on start; IDLE -> RUN on start.
REQ-018 SHALL, on start in IDLE or DONE, clear all accumulators, max values and count in the same edge that enters RUN.
REQ-019 SHALL ignore start in RUN and DRAIN.
REQ-020 SHALL drive in_ready=1 only in RUN; a handshake is in_valid&&in_ready on a rising edge.
REQ-021 SHALL compute per channel err = var - acc modulo 2^WIDTH, interpreted as signed WIDTH, sign-extended to ACC_W.
REQ-022 SHALL compute |err| as unsigned WIDTH; -2^(WIDTH-1) yields 2^(WIDTH-1).
REQ-023 SHALL pipeline in 2 stages: stage 1 registers err; stage 2 updates sum (wrap modulo 2^ACC_W) and max.
REQ-024 SHALL increment count on each handshake; on the NSAMP-th handshake, go to DRAIN with in_ready=0 from the next cycle.
REQ-025 SHALL stay in DRAIN 2 cycles, then enter DONE; done=1 exactly when the final sample is reflected in every statistic.
REQ-026 SHALL hold busy=1 in RUN and DRAIN; done=1 only in DONE, held until the next start.
REQ-027 SHALL keep statistics stable in DONE and IDLE; sum_err/max_abs are a combinational mux of registered values by ch_sel.
REQ-028 SHALL output channel 0 statistics when ch_sel >= NCH.

Reset
REQ-029 SHALL, on rst_n low, immediately force IDLE, in_ready=0, busy=0, done=0, count=0, all sums and max values 0, pipeline valid flags 0.
REQ-030 SHALL discard a run in progress on reset; no partial statistic survives.

Configuration
REQ-031 SHALL, with ARF_ERR_SQ_EN defined, add output sq_err (ACC_W, unsigned) holding the sum of err^2 truncated to ACC_W for channel ch_sel, updated in stage 2, reset/cleared like sum_err.
REQ-032 SHALL, without ARF_ERR_SQ_EN, have no sq_err port and no multiplier.

Structure
REQ-033 SHALL place the FSM state enum and default parameter constants in shared package arf_pkg.
REQ-034 SHALL implement the per-channel diff/abs/accumulate path as sub-module arf_err_lane, instantiated NCH times.

Verification
REQ-035 SHALL test reset mid-RUN: 3 samples accepted, rst_n low -> IDLE, count=0, sum_err=0, done=0.
REQ-036 SHALL test NSAMP=4, NCH=2 with var=acc on all samples -> done after 4 handshakes + 2 cycles, sum_err=0, max_abs=0, count=4.
REQ-037 SHALL test ch0 var=5, acc=8 for 4 samples -> sum_err=-12, max_abs=3; ch1 var=10, acc=7 -> sum_err=+12, max_abs=3; with ARF_ERR_SQ_EN, sq_err=36 on both channels.
REQ-038 SHALL test WIDTH=32 with var=32'h8000_0000, acc=0 -> max_abs=32'h8000_0000, sum_err=-2^31 sign-extended.
REQ-039 SHALL test in_valid gaps and start pulses during RUN -> only handshakes counted, start ignored, in_ready=0 after the 4th handshake.
REQ-040 SHALL test start in DONE -> statistics cleared next edge, busy=1, done=0, new run counts from 0.

Source files
------------

// File: rtl/arf_pkg.sv
// Shared definitions for the filter-error statistics block: FSM states and default sizing.
package arf_pkg;

    localparam int unsigned ARF_WIDTH = 32;
    localparam int unsigned ARF_NCH   = 2;
    localparam int unsigned ARF_NSAMP = 100;
    localparam int unsigned ARF_ACC_W = 64;
    localparam int unsigned ARF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } arf_state_e;

endpackage

// File: rtl/arf_err_lane.sv
// One channel of error statistics: stage 1 registers var-acc, stage 2 accumulates sum and max |err|.
// With ARF_ERR_SQ_EN defined, stage 2 also accumulates err^2.
module arf_err_lane
    import arf_pkg::*;
#(
    parameter int unsigned WIDTH = ARF_WIDTH,
    parameter int unsigned ACC_W = ARF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             hs_i,
    input  logic [WIDTH-1:0] var_i,
    input  logic [WIDTH-1:0] acc_i,
    output logic [ACC_W-1:0] sum_o,
    output logic [WIDTH-1:0] max_o
`ifdef ARF_ERR_SQ_EN
    ,
    output logic [ACC_W-1:0] sq_o
`endif
);

    logic [WIDTH-1:0] err_q, err_d;
    logic             vld_q, vld_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [ACC_W-1:0] err_ext_c;
    logic [WIDTH-1:0] abs_c;
`ifdef ARF_ERR_SQ_EN
    logic [ACC_W-1:0] sq_q, sq_d;
`endif

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) as unsigned.
    always_comb begin
        err_d     = hs_i ? (var_i - acc_i) : err_q;
        vld_d     = hs_i;
        err_ext_c = {{(ACC_W-WIDTH){err_q[WIDTH-1]}}, err_q};
        abs_c     = err_q[WIDTH-1] ? (~err_q + WIDTH'(1)) : err_q;
        sum_d     = sum_q;
        max_d     = max_q;
`ifdef ARF_ERR_SQ_EN
        sq_d      = sq_q;
`endif
        if (clr_i) begin
            sum_d = '0;
            max_d = '0;
`ifdef ARF_ERR_SQ_EN
            sq_d  = '0;
`endif
        end else if (vld_q) begin
            sum_d = sum_q + err_ext_c;
            if (abs_c > max_q) max_d = abs_c;
`ifdef ARF_ERR_SQ_EN
            sq_d  = sq_q + ACC_W'(err_ext_c * err_ext_c);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            vld_q <= 1'b0;
            sum_q <= '0;
            max_q <= '0;
`ifdef ARF_ERR_SQ_EN
            sq_q  <= '0;
`endif
        end else begin
            err_q <= err_d;
            vld_q <= vld_d;
            sum_q <= sum_d;
            max_q <= max_d;
`ifdef ARF_ERR_SQ_EN
            sq_q  <= sq_d;
`endif
        end
    end

    assign sum_o = sum_q;
    assign max_o = max_q;
`ifdef ARF_ERR_SQ_EN
    assign sq_o  = sq_q;
`endif

endmodule

// File: rtl/arf_err_stat.sv
// Compares approximate vs accurate filter outputs over NSAMP samples and keeps per-channel error statistics.
// Optional ARF_ERR_SQ_EN adds a sum-of-squared-error output.
module arf_err_stat
    import arf_pkg::*;
#(
    parameter int unsigned WIDTH = ARF_WIDTH,
    parameter int unsigned NCH   = ARF_NCH,
    parameter int unsigned NSAMP = ARF_NSAMP,
    parameter int unsigned ACC_W = ARF_ACC_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NCH*WIDTH-1:0]                 var_out,
    input  logic [NCH*WIDTH-1:0]                 acc_out,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_sel,
    output logic [ACC_W-1:0]                     sum_err,
    output logic [WIDTH-1:0]                     max_abs,
`ifdef ARF_ERR_SQ_EN
    output logic [ACC_W-1:0]                     sq_err,
`endif
    output logic [ARF_CNT_W-1:0]                 count,
    output logic                                 busy,
    output logic                                 done
);

    arf_state_e           state_q, state_d;
    logic [ARF_CNT_W-1:0] count_q, count_d;
    logic                 drain_q, drain_d;
    logic                 hs_c, clr_c;

    logic [ACC_W-1:0] sum_arr [NCH];
    logic [WIDTH-1:0] max_arr [NCH];
`ifdef ARF_ERR_SQ_EN
    logic [ACC_W-1:0] sq_arr  [NCH];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            drain_q <= drain_d;
        end
    end

    // Two-cycle drain lets the last sample pass both lane pipeline stages before done.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        drain_d = drain_q;
        clr_c   = 1'b0;
        hs_c    = (state_q == ST_RUN) && in_valid;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    count_d = '0;
                    clr_c   = 1'b1;
                end
            end
            ST_RUN: begin
                if (hs_c) begin
                    count_d = count_q + ARF_CNT_W'(1);
                    if (count_q == ARF_CNT_W'(NSAMP - 1)) begin
                        state_d = ST_DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q) state_d = ST_DONE;
                else         drain_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_RUN);
        busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done     = (state_q == ST_DONE);
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        arf_err_lane #(
            .WIDTH (WIDTH),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (clr_c),
            .hs_i  (hs_c),
            .var_i (var_out[k*WIDTH +: WIDTH]),
            .acc_i (acc_out[k*WIDTH +: WIDTH]),
            .sum_o (sum_arr[k]),
            .max_o (max_arr[k])
`ifdef ARF_ERR_SQ_EN
            ,
            .sq_o  (sq_arr[k])
`endif
        );
    end

    // Out-of-range selects fall back to channel 0.
    always_comb begin
        sum_err = sum_arr[0];
        max_abs = max_arr[0];
`ifdef ARF_ERR_SQ_EN
        sq_err  = sq_arr[0];
`endif
        for (int unsigned k = 0; k < NCH; k++) begin
            if (32'(ch_sel) == k) begin
                sum_err = sum_arr[k];
                max_abs = max_arr[k];
`ifdef ARF_ERR_SQ_EN
                sq_err  = sq_arr[k];
`endif
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_arf_err_stat.sv
// Scoreboard bench for arf_err_stat (NSAMP=4, NCH=2): expected run results are queued at run start
// and checked by a monitor when done rises; control timing is checked inline.
module tb_arf_err_stat;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 2;
    localparam int unsigned NS = 4;
    localparam int unsigned AW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N*W-1:0] var_out = '0;
    logic [N*W-1:0] acc_out = '0;
    logic          ch_sel = 1'b0;
    logic [AW-1:0] sum_err;
    logic [W-1:0]  max_abs;
    logic [15:0]   count;
    logic          busy;
    logic          done;
`ifdef ARF_ERR_SQ_EN
    logic [AW-1:0] sq_err;
`endif

    typedef struct {
        logic [AW-1:0] sum0;
        logic [AW-1:0] sum1;
        logic [W-1:0]  mx0;
        logic [W-1:0]  mx1;
        logic [AW-1:0] sq0;
        logic [AW-1:0] sq1;
        logic [15:0]   cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t tmp_e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic done_prev = 1'b0;

    arf_err_stat #(
        .WIDTH (W),
        .NCH   (N),
        .NSAMP (NS),
        .ACC_W (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .var_out  (var_out),
        .acc_out  (acc_out),
        .ch_sel   (ch_sel),
        .sum_err  (sum_err),
        .max_abs  (max_abs),
`ifdef ARF_ERR_SQ_EN
        .sq_err   (sq_err),
`endif
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // One clock of stimulus; hs reports whether this cycle was a handshake.
    task automatic cyc(input logic st, input logic vld, input logic [31:0] v0, input logic [31:0] a0,
                       input logic [31:0] v1, input logic [31:0] a1, output logic hs);
        @(negedge clk);
        start    = st;
        in_valid = vld;
        var_out  = {v1, v0};
        acc_out  = {a1, a0};
        hs       = vld & in_ready;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] v0, input logic [31:0] a0, input logic [31:0] v1, input logic [31:0] a1);
        logic h;
        h = 1'b0;
        for (int t = 0; t < 10 && !h; t++) cyc(1'b0, 1'b1, v0, a0, v1, a1, h);
        if (!h) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_start();
        logic h;
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, h);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    // Monitor: compares the queued expectation for both channels when a run completes.
    initial begin
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    chk("sb_empty_on_done", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    ch_sel = 1'b0;
                    #1;
                    chk("sum_ch0", sum_err, mon_e.sum0);
                    chk("max_ch0", 64'(max_abs), 64'(mon_e.mx0));
`ifdef ARF_ERR_SQ_EN
                    chk("sq_ch0", sq_err, mon_e.sq0);
`endif
                    ch_sel = 1'b1;
                    #1;
                    chk("sum_ch1", sum_err, mon_e.sum1);
                    chk("max_ch1", 64'(max_abs), 64'(mon_e.mx1));
`ifdef ARF_ERR_SQ_EN
                    chk("sq_ch1", sq_err, mon_e.sq1);
`endif
                    chk("count_done", 64'(count), 64'(mon_e.cnt));
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic h;
        int   nh;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_sum", sum_err, 64'd0);
        chk("rst_max", 64'(max_abs), 64'd0);
        rst_n = 1'b1;

        // Reset in the middle of a run
        do_start();
        for (int i = 0; i < 3; i++) send(32'd5, 32'd8, 32'd10, 32'd7);
        @(negedge clk);
        chk("pre_reset_count", 64'(count), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd0);
        chk("mrst_sum", sum_err, 64'd0);
        chk("mrst_max", 64'(max_abs), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // var == acc: all-zero statistics, done two cycles after the last handshake
        do_start();
        tmp_e = '{sum0: 64'd0, sum1: 64'd0, mx0: 32'd0, mx1: 32'd0, sq0: 64'd0, sq1: 64'd0, cnt: 16'd4};
        sb.push_back(tmp_e);
        for (int i = 0; i < 4; i++) send(32'd7 + 32'(i), 32'd7 + 32'(i), 32'd9, 32'd9);
        @(negedge clk);
        chk("drain1_in_ready", 64'(in_ready), 64'd0);
        chk("drain1_busy", 64'(busy), 64'd1);
        chk("drain1_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("drain2_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("done_timing", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);

        // ch0 err=-3, ch1 err=+3 on every sample
        do_start();
        tmp_e = '{sum0: 64'hFFFF_FFFF_FFFF_FFF4, sum1: 64'd12, mx0: 32'd3, mx1: 32'd3,
                  sq0: 64'd36, sq1: 64'd36, cnt: 16'd4};
        sb.push_back(tmp_e);
        for (int i = 0; i < 4; i++) send(32'd5, 32'd8, 32'd10, 32'd7);
        wait_done();

        // Start while DONE clears everything on the same edge
        repeat (2) @(negedge clk);
        do_start();
        @(negedge clk);
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_count", 64'(count), 64'd0);
        chk("restart_sum", sum_err, 64'd0);
        chk("restart_max", 64'(max_abs), 64'd0);

        // Most negative error on ch0; ch1 err=-1 each sample
        tmp_e = '{sum0: 64'hFFFF_FFFF_8000_0000, sum1: 64'hFFFF_FFFF_FFFF_FFFC,
                  mx0: 32'h8000_0000, mx1: 32'd1,
                  sq0: 64'h4000_0000_0000_0000, sq1: 64'd4, cnt: 16'd4};
        sb.push_back(tmp_e);
        send(32'h8000_0000, 32'd0, 32'd0, 32'd1);
        for (int i = 0; i < 3; i++) send(32'd3, 32'd3, 32'd0, 32'd1);
        wait_done();

        // Valid gaps and start pulses during RUN
        repeat (2) @(negedge clk);
        do_start();
        tmp_e = '{sum0: 64'd10, sum1: 64'hFFFF_FFFF_FFFF_FFF8, mx0: 32'd4, mx1: 32'd2,
                  sq0: 64'd30, sq1: 64'd16, cnt: 16'd4};
        sb.push_back(tmp_e);
        nh = 0;
        cyc(1'b0, 1'b1, 32'd1, 32'd0, 32'd0, 32'd2, h); nh += int'(h);
        cyc(1'b0, 1'b0, 32'd9, 32'd0, 32'd0, 32'd9, h); nh += int'(h);
        cyc(1'b1, 1'b1, 32'd2, 32'd0, 32'd0, 32'd2, h); nh += int'(h);
        cyc(1'b1, 1'b0, 32'd9, 32'd0, 32'd0, 32'd9, h); nh += int'(h);
        cyc(1'b0, 1'b0, 32'd9, 32'd0, 32'd0, 32'd9, h); nh += int'(h);
        chk("gap_count", 64'(count), 64'd2);
        chk("gap_busy", 64'(busy), 64'd1);
        cyc(1'b1, 1'b1, 32'd3, 32'd0, 32'd0, 32'd2, h); nh += int'(h);
        cyc(1'b0, 1'b0, 32'd9, 32'd0, 32'd0, 32'd9, h); nh += int'(h);
        cyc(1'b0, 1'b1, 32'd4, 32'd0, 32'd0, 32'd2, h); nh += int'(h);
        chk("gap_hs_total", 64'(nh), 64'd4);
        cyc(1'b0, 1'b1, 32'd50, 32'd0, 32'd0, 32'd50, h);
        chk("no_hs_after_last", 64'(h), 64'd0);
        chk("post_last_count", 64'(count), 64'd4);
        wait_done();

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
